// File: rtl/w_stage_grf_pkg.sv
// rtl/w_stage_grf_pkg.sv - shared write-back select encodings and register constants
package w_stage_grf_pkg;

  typedef enum logic [3:0] {
    WB_ALU = 4'd0,
    WB_DM  = 4'd1,
    WB_PC8 = 4'd2,
    WB_CMP = 4'd3,
    WB_MDU = 4'd4
  } wb_sel_e;

  localparam logic [4:0]  REG_ZERO   = 5'd0;
  localparam logic [31:0] PC8_OFFSET = 32'd8;

endpackage

// File: rtl/w_stage_grf_if.sv
// rtl/w_stage_grf_if.sv - W-stage bundle, D-stage read ports and status outputs
interface w_stage_grf_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 32
);
  logic [31:0]       W_PC;
  logic [31:0]       W_instr;
  logic [ADDR_W-1:0] W_GRF_A3;
  logic              W_GRF_write;
  logic [SEL_W-1:0]  W_GRF_DatatoReg;
  logic [DATA_W-1:0] W_ALUout;
  logic [DATA_W-1:0] W_DMout;
  logic [DATA_W-1:0] W_CMP_result;
  logic [DATA_W-1:0] W_MDUout;
  logic [3:0]        W_Tnew;
  logic [ADDR_W-1:0] D_rs_addr;
  logic [ADDR_W-1:0] D_rt_addr;
  logic [DATA_W-1:0] D_rs_data;
  logic [DATA_W-1:0] D_rt_data;
  logic [ADDR_W-1:0] W_fwd_addr;
  logic [DATA_W-1:0] W_fwd_data;
  logic [CNT_W-1:0]  retire_cnt;
  logic              wb_err;

  modport master (
    output W_PC, W_instr, W_GRF_A3, W_GRF_write, W_GRF_DatatoReg,
           W_ALUout, W_DMout, W_CMP_result, W_MDUout, W_Tnew,
           D_rs_addr, D_rt_addr,
    input  D_rs_data, D_rt_data, W_fwd_addr, W_fwd_data, retire_cnt, wb_err
  );

  modport slave (
    input  W_PC, W_instr, W_GRF_A3, W_GRF_write, W_GRF_DatatoReg,
           W_ALUout, W_DMout, W_CMP_result, W_MDUout, W_Tnew,
           D_rs_addr, D_rt_addr,
    output D_rs_data, D_rt_data, W_fwd_addr, W_fwd_data, retire_cnt, wb_err
  );
endinterface

// File: rtl/w_stage_grf_wb_sel.sv
// rtl/w_stage_grf_wb_sel.sv - combinational write-back source mux with PC+8 link value
module w_stage_grf_wb_sel
  import w_stage_grf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic [SEL_W-1:0]  sel,
  input  logic [31:0]       pc,
  input  logic [DATA_W-1:0] alu,
  input  logic [DATA_W-1:0] dm,
  input  logic [DATA_W-1:0] cmp,
  input  logic [DATA_W-1:0] mdu,
  output logic [DATA_W-1:0] value
);

  logic [31:0] pc_plus8;

  // Link value wraps at 2**32; the carry out is intentionally dropped.
  assign pc_plus8 = pc + PC8_OFFSET;

  always_comb begin
    value = '0;
    case (sel)
      SEL_W'(WB_ALU): value = alu;
      SEL_W'(WB_DM):  value = dm;
      SEL_W'(WB_PC8): value = DATA_W'(pc_plus8);
      SEL_W'(WB_CMP): value = cmp;
      SEL_W'(WB_MDU): value = mdu;
      default:        value = '0;
    endcase
  end

endmodule

// File: rtl/w_stage_grf.sv
// rtl/w_stage_grf.sv - W-stage commit into the 32x32 register file with W->D bypass,
// retire counter and sticky Tnew-violation flag.
module w_stage_grf
  import w_stage_grf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 32
) (
  input  logic          clk,
  input  logic          reset,
  w_stage_grf_if.slave  bus
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] wb_value;
  logic              we;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;

  w_stage_grf_wb_sel #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_wb_sel (
    .sel   (bus.W_GRF_DatatoReg),
    .pc    (bus.W_PC),
    .alu   (bus.W_ALUout),
    .dm    (bus.W_DMout),
    .cmp   (bus.W_CMP_result),
    .mdu   (bus.W_MDUout),
    .value (wb_value)
  );

  assign we = bus.W_GRF_write && (bus.W_GRF_A3 != ADDR_W'(REG_ZERO));

  assign bus.W_fwd_addr = we ? bus.W_GRF_A3 : '0;
  assign bus.W_fwd_data = we ? wb_value : '0;

  // Same-cycle bypass lets D read the value W is about to commit.
  always_comb begin
    bus.D_rs_data = '0;
    if (bus.D_rs_addr == ADDR_W'(REG_ZERO))
      bus.D_rs_data = '0;
    else if (we && bus.D_rs_addr == bus.W_GRF_A3)
      bus.D_rs_data = wb_value;
    else
      bus.D_rs_data = regs[bus.D_rs_addr];
  end

  always_comb begin
    bus.D_rt_data = '0;
    if (bus.D_rt_addr == ADDR_W'(REG_ZERO))
      bus.D_rt_data = '0;
    else if (we && bus.D_rt_addr == bus.W_GRF_A3)
      bus.D_rt_data = wb_value;
    else
      bus.D_rt_data = regs[bus.D_rt_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (we) regs[bus.W_GRF_A3] <= wb_value;
      if (bus.W_instr != 32'd0) cnt_q <= cnt_q + 1'b1;
      // The write still lands; this only records that the hazard unit let it through early.
      if (bus.W_GRF_write && bus.W_Tnew != 4'd0) err_q <= 1'b1;
    end
  end

  assign bus.retire_cnt = cnt_q;
  assign bus.wb_err     = err_q;

endmodule
